// File: rtl/fetch_unit.sv
// Program counter and fetch stage: drives the IM word address and registers the returned
// instruction for decode, with branch/jump redirects, stall, halt/resume and range fault.
module fetch_unit #(
    parameter int                ADDR_W    = 16,
    parameter int                INSN_W    = 32,
    parameter int                MEM_DEPTH = 256,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] im_addr,
    input  logic [INSN_W-1:0] im_data,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_offset,
    input  logic              jmp_valid,
    input  logic [ADDR_W-1:0] jmp_target,
    input  logic              halt_req,
    input  logic              resume,
    output logic [INSN_W-1:0] ir,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              ir_valid,
    output logic              halted,
    output logic              fault,
    output logic [1:0]        fsm_state
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } state_t;

    // One bit wider than the PC so a depth of exactly 2^ADDR_W is representable.
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(MEM_DEPTH);

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              redirect_ok;
    logic              pc_ok;

    assign im_addr   = pc;
    assign fsm_state = state;

    // Redirects only act on a live instruction; jump outranks branch.
    always_comb begin
        redirect    = ir_valid & (jmp_valid | br_taken);
        redirect_pc = jmp_valid ? jmp_target : (ir_pc + br_offset);
        redirect_ok = ({1'b0, redirect_pc} < DEPTH_LIM);
        pc_ok       = ({1'b0, pc} < DEPTH_LIM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= BOOT;
            pc       <= RESET_PC;
            ir       <= '0;
            ir_pc    <= '0;
            ir_valid <= 1'b0;
            halted   <= 1'b0;
            fault    <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state <= RUN;
                end
                RUN: begin
                    if (redirect) begin
                        // Wrong-path fetch is dropped; a bad target is kept in pc for inspection.
                        pc       <= redirect_pc;
                        ir_valid <= 1'b0;
                        if (!redirect_ok) begin
                            state <= FAULT;
                            fault <= 1'b1;
                        end
                    end else if (halt_req) begin
                        state    <= HALT;
                        halted   <= 1'b1;
                        ir_valid <= 1'b0;
                    end else if (stall) begin
                        state <= RUN;
                    end else if (!pc_ok) begin
                        state    <= FAULT;
                        fault    <= 1'b1;
                        ir_valid <= 1'b0;
                    end else begin
                        ir       <= im_data;
                        ir_pc    <= pc;
                        ir_valid <= 1'b1;
                        pc       <= pc + 1'b1;
                    end
                end
                HALT: begin
                    if (resume) begin
                        state  <= RUN;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    state <= FAULT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic against a
// behavioural model of the fetch stage built from integer PC arithmetic.
module tb_fetch_unit;

    localparam int AW    = 16;
    localparam int IW    = 32;
    localparam int DEPTH = 256;
    localparam int M_BOOT = 0, M_RUN = 1, M_HALT = 2, M_FAULT = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] im_addr;
    logic [IW-1:0] im_data;
    logic          stall = 1'b0, br_taken = 1'b0, jmp_valid = 1'b0;
    logic          halt_req = 1'b0, resume = 1'b0;
    logic [AW-1:0] br_offset = '0, jmp_target = '0;
    logic [IW-1:0] ir;
    logic [AW-1:0] ir_pc;
    logic          ir_valid, halted, fault;
    logic [1:0]    fsm_state;

    logic [IW-1:0] mem [DEPTH];

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    int            m_mode;
    int            m_pc;
    int            m_ir_pc;
    int            m_ir_valid;
    logic [IW-1:0] m_ir;

    fetch_unit #(.ADDR_W(AW), .INSN_W(IW), .MEM_DEPTH(DEPTH), .RESET_PC('0)) dut (
        .clk(clk), .rst_n(rst_n), .im_addr(im_addr), .im_data(im_data),
        .stall(stall), .br_taken(br_taken), .br_offset(br_offset),
        .jmp_valid(jmp_valid), .jmp_target(jmp_target), .halt_req(halt_req),
        .resume(resume), .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid),
        .halted(halted), .fault(fault), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    assign im_data = (im_addr < 16'(DEPTH)) ? mem[im_addr[7:0]] : {16'hBAD0, im_addr};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_mode = M_BOOT; m_pc = 0; m_ir_pc = 0; m_ir_valid = 0; m_ir = '0;
    endtask

    task automatic model_edge();
        int tgt;
        case (m_mode)
            M_BOOT: m_mode = M_RUN;
            M_RUN: begin
                if (m_ir_valid != 0 && (jmp_valid || br_taken)) begin
                    if (jmp_valid) tgt = int'(jmp_target);
                    else tgt = (m_ir_pc + int'($signed(br_offset)) + 65536) % 65536;
                    m_pc = tgt;
                    m_ir_valid = 0;
                    if (tgt >= DEPTH) m_mode = M_FAULT;
                end else if (halt_req) begin
                    m_mode = M_HALT;
                    m_ir_valid = 0;
                end else if (stall) begin
                    m_pc = m_pc;
                end else if (m_pc >= DEPTH) begin
                    m_mode = M_FAULT;
                    m_ir_valid = 0;
                end else begin
                    m_ir = mem[m_pc];
                    m_ir_pc = m_pc;
                    m_ir_valid = 1;
                    m_pc = (m_pc + 1) % 65536;
                end
            end
            M_HALT: if (resume) m_mode = M_RUN;
            default: m_mode = M_FAULT;
        endcase
    endtask

    task automatic clear_inputs();
        stall = 0; br_taken = 0; jmp_valid = 0; halt_req = 0; resume = 0;
        br_offset = '0; jmp_target = '0;
    endtask

    // Advance one clock; inputs are sampled by the model before the edge, outputs read 1ns after.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic run_steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst_n = 0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic test_reset();
        clear_inputs();
        #2;
        rst_n = 0;
        model_reset();
        #1;
        vectors++;
        if (ir_valid !== 1'b0 || halted !== 1'b0 || fault !== 1'b0 || ir !== '0 ||
            ir_pc !== '0 || im_addr !== '0) begin
            miscompares++;
            $display("FAIL reset_values: got valid=%b halted=%b fault=%b ir=%h ir_pc=%0d im_addr=%0d want all zero",
                     ir_valid, halted, fault, ir, ir_pc, im_addr);
        end
        @(posedge clk);
        #1;
        rst_n = 1;
        step();
        vectors++;
        if (ir_valid !== 1'b0 || im_addr !== 16'd0) begin
            miscompares++;
            $display("FAIL boot_cycle: got valid=%b im_addr=%0d want valid=0 im_addr=0", ir_valid, im_addr);
        end
    endtask

    task automatic test_sequential();
        apply_reset();
        step();
        for (int k = 0; k < 3; k++) begin
            step();
            vectors++;
            if (ir_valid !== 1'b1 || ir !== mem[k] || ir_pc !== 16'(k)) begin
                miscompares++;
                $display("FAIL seq_fetch_%0d: got valid=%b ir=%h ir_pc=%0d want valid=1 ir=%h ir_pc=%0d",
                         k, ir_valid, ir, ir_pc, mem[k], k);
            end
        end
    endtask

    task automatic test_branch();
        apply_reset();
        run_steps(12);
        br_taken = 1; br_offset = 16'd2;
        step();
        br_taken = 0; br_offset = '0;
        vectors++;
        if (ir_valid !== 1'b0 || im_addr !== 16'd12) begin
            miscompares++;
            $display("FAIL branch_bubble: got valid=%b im_addr=%0d want valid=0 im_addr=12", ir_valid, im_addr);
        end
        step();
        vectors++;
        if (ir_valid !== 1'b1 || ir_pc !== 16'd12 || ir !== mem[12]) begin
            miscompares++;
            $display("FAIL branch_fwd: got valid=%b ir_pc=%0d ir=%h want valid=1 ir_pc=12 ir=%h",
                     ir_valid, ir_pc, ir, mem[12]);
        end
        apply_reset();
        run_steps(7);
        br_taken = 1; br_offset = 16'hFFFE;
        step();
        br_taken = 0; br_offset = '0;
        step();
        vectors++;
        if (ir_valid !== 1'b1 || ir_pc !== 16'd3 || ir !== mem[3]) begin
            miscompares++;
            $display("FAIL branch_back: got valid=%b ir_pc=%0d ir=%h want valid=1 ir_pc=3 ir=%h",
                     ir_valid, ir_pc, ir, mem[3]);
        end
    endtask

    task automatic test_jump_priority();
        apply_reset();
        run_steps(10);
        jmp_valid = 1; jmp_target = 16'd4; br_taken = 1; br_offset = 16'd40; stall = 1;
        step();
        clear_inputs();
        vectors++;
        if (ir_valid !== 1'b0 || im_addr !== 16'd4) begin
            miscompares++;
            $display("FAIL jump_wins: got valid=%b im_addr=%0d want valid=0 im_addr=4", ir_valid, im_addr);
        end
        step();
        vectors++;
        if (ir_valid !== 1'b1 || ir_pc !== 16'd4 || ir !== mem[4]) begin
            miscompares++;
            $display("FAIL jump_target: got valid=%b ir_pc=%0d want valid=1 ir_pc=4", ir_valid, ir_pc);
        end
        jmp_valid = 1; jmp_target = 16'd20; halt_req = 1;
        step();
        jmp_valid = 0;
        vectors++;
        if (halted !== 1'b0 || im_addr !== 16'd20) begin
            miscompares++;
            $display("FAIL jump_over_halt: got halted=%b im_addr=%0d want halted=0 im_addr=20", halted, im_addr);
        end
        step();
        halt_req = 0;
        vectors++;
        if (halted !== 1'b1 || ir_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL halt_next_cycle: got halted=%b valid=%b want halted=1 valid=0", halted, ir_valid);
        end
        resume = 1;
        step();
        resume = 0;
        step();
        vectors++;
        if (ir_valid !== 1'b1 || ir_pc !== 16'd20 || ir !== mem[20]) begin
            miscompares++;
            $display("FAIL resume_at_target: got valid=%b ir_pc=%0d want valid=1 ir_pc=20", ir_valid, ir_pc);
        end
    endtask

    task automatic test_stall();
        apply_reset();
        run_steps(8);
        stall = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            vectors++;
            if (im_addr !== 16'd7 || ir_pc !== 16'd6 || ir !== mem[6] || ir_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL stall_hold_%0d: got im_addr=%0d ir_pc=%0d valid=%b want im_addr=7 ir_pc=6 valid=1",
                         k, im_addr, ir_pc, ir_valid);
            end
        end
        stall = 0;
        step();
        vectors++;
        if (ir_pc !== 16'd7 || ir !== mem[7] || ir_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_release: got ir_pc=%0d valid=%b want ir_pc=7 valid=1", ir_pc, ir_valid);
        end
    endtask

    task automatic test_halt();
        apply_reset();
        run_steps(10);
        halt_req = 1;
        step();
        halt_req = 0;
        for (int k = 0; k < 5; k++) begin
            jmp_valid = (k == 2);
            jmp_target = 16'd50;
            step();
            vectors++;
            if (halted !== 1'b1 || ir_valid !== 1'b0 || im_addr !== 16'd9) begin
                miscompares++;
                $display("FAIL halt_hold_%0d: got halted=%b valid=%b im_addr=%0d want halted=1 valid=0 im_addr=9",
                         k, halted, ir_valid, im_addr);
            end
        end
        clear_inputs();
        resume = 1;
        step();
        resume = 0;
        vectors++;
        if (halted !== 1'b0 || ir_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL resume_exit: got halted=%b valid=%b want halted=0 valid=0", halted, ir_valid);
        end
        step();
        vectors++;
        if (ir_valid !== 1'b1 || ir_pc !== 16'd9 || ir !== mem[9]) begin
            miscompares++;
            $display("FAIL resume_refetch: got valid=%b ir_pc=%0d want valid=1 ir_pc=9", ir_valid, ir_pc);
        end
    endtask

    task automatic test_end_of_memory();
        apply_reset();
        run_steps(3);
        jmp_valid = 1; jmp_target = 16'd254;
        step();
        clear_inputs();
        step();
        step();
        vectors++;
        if (ir_valid !== 1'b1 || ir_pc !== 16'd255 || ir !== mem[255]) begin
            miscompares++;
            $display("FAIL last_word: got valid=%b ir_pc=%0d want valid=1 ir_pc=255", ir_valid, ir_pc);
        end
        step();
        vectors++;
        if (fault !== 1'b1 || ir_valid !== 1'b0 || im_addr !== 16'd256) begin
            miscompares++;
            $display("FAIL seq_overrun: got fault=%b valid=%b im_addr=%0d want fault=1 valid=0 im_addr=256",
                     fault, ir_valid, im_addr);
        end
    endtask

    task automatic test_fault();
        apply_reset();
        run_steps(4);
        jmp_valid = 1; jmp_target = 16'd300;
        step();
        clear_inputs();
        vectors++;
        if (fault !== 1'b1 || ir_valid !== 1'b0 || im_addr !== 16'd300) begin
            miscompares++;
            $display("FAIL fault_entry: got fault=%b valid=%b im_addr=%0d want fault=1 valid=0 im_addr=300",
                     fault, ir_valid, im_addr);
        end
        for (int k = 0; k < 6; k++) begin
            resume = 1'($urandom_range(0, 1)); halt_req = 1'($urandom_range(0, 1));
            jmp_valid = 1; jmp_target = 16'($urandom_range(0, 100)); stall = 1'($urandom_range(0, 1));
            step();
            vectors++;
            if (fault !== 1'b1 || ir_valid !== 1'b0 || halted !== 1'b0 || im_addr !== 16'd300) begin
                miscompares++;
                $display("FAIL fault_sticky_%0d: got fault=%b valid=%b halted=%b im_addr=%0d want 1/0/0/300",
                         k, fault, ir_valid, halted, im_addr);
            end
        end
        clear_inputs();
        #2;
        rst_n = 0;
        model_reset();
        #1;
        vectors++;
        if (fault !== 1'b0 || im_addr !== 16'd0 || ir_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL fault_clear: got fault=%b im_addr=%0d valid=%b want 0/0/0", fault, im_addr, ir_valid);
        end
        @(posedge clk);
        #1;
        rst_n = 1;
        run_steps(6);
        #2;
        rst_n = 0;
        model_reset();
        #1;
        vectors++;
        if (ir_valid !== 1'b0 || ir !== '0 || ir_pc !== '0 || im_addr !== '0 || halted !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: got valid=%b ir=%h ir_pc=%0d im_addr=%0d halted=%b want all zero",
                     ir_valid, ir, ir_pc, im_addr, halted);
        end
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic test_random();
        int fault_cycles;
        apply_reset();
        fault_cycles = 0;
        for (int n = 0; n < 600; n++) begin
            stall      = ($urandom_range(0, 5) == 0);
            br_taken   = ($urandom_range(0, 7) == 0);
            br_offset  = 16'(int'($urandom_range(0, 40)) - 20);
            jmp_valid  = ($urandom_range(0, 15) == 0);
            jmp_target = 16'($urandom_range(0, 270));
            halt_req   = ($urandom_range(0, 31) == 0);
            resume     = ($urandom_range(0, 3) == 0);
            step();
            vectors++;
            if (ir_valid !== 1'(m_ir_valid) || ir_pc !== 16'(m_ir_pc) || ir !== m_ir ||
                im_addr !== 16'(m_pc) || halted !== (m_mode == M_HALT) || fault !== (m_mode == M_FAULT)) begin
                miscompares++;
                $display("FAIL random_%0d: got valid=%b ir_pc=%0d ir=%h pc=%0d halted=%b fault=%b st=%0d want valid=%0d ir_pc=%0d ir=%h pc=%0d mode=%0d",
                         n, ir_valid, ir_pc, ir, im_addr, halted, fault, fsm_state,
                         m_ir_valid, m_ir_pc, m_ir, m_pc, m_mode);
            end
            if (m_mode == M_FAULT) fault_cycles++;
            if (fault_cycles > 4) begin
                apply_reset();
                fault_cycles = 0;
            end
        end
        clear_inputs();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom();
        model_reset();
        test_reset();
        test_sequential();
        test_branch();
        test_jump_priority();
        test_stall();
        test_halt();
        test_end_of_memory();
        test_fault();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
